// File: rtl/seat_lookup_if.sv
// Request/result and table read-port bundle for seat_lookup.
// The master side is the requester that also owns the seat table.
// The slave side is the lookup engine.
interface seat_lookup_if #(
    parameter int unsigned NUM_SEATS = 32,
    parameter int unsigned STU_W     = 25,
    parameter int unsigned SEAT_W    = 8
);
    localparam int unsigned AW = $clog2(NUM_SEATS);

    logic              start_seat_lookup;
    logic              mode_seat_lookup;
    logic [STU_W-1:0]  Student_No_seat_lookup;
    logic [SEAT_W-1:0] Seat_No_seat_lookup;
    logic              rd_en_seat_lookup;
    logic [AW-1:0]     rd_addr_seat_lookup;
    logic [STU_W-1:0]  rd_data_seat_lookup;
    logic              busy_seat_lookup;
    logic              done_seat_lookup;
    logic              found_seat_lookup;
    logic [SEAT_W-1:0] Seat_No_out_seat_lookup;
    logic [STU_W-1:0]  Student_No_out_seat_lookup;

    modport master (
        output start_seat_lookup,
        output mode_seat_lookup,
        output Student_No_seat_lookup,
        output Seat_No_seat_lookup,
        input  rd_en_seat_lookup,
        input  rd_addr_seat_lookup,
        output rd_data_seat_lookup,
        input  busy_seat_lookup,
        input  done_seat_lookup,
        input  found_seat_lookup,
        input  Seat_No_out_seat_lookup,
        input  Student_No_out_seat_lookup
    );

    modport slave (
        input  start_seat_lookup,
        input  mode_seat_lookup,
        input  Student_No_seat_lookup,
        input  Seat_No_seat_lookup,
        output rd_en_seat_lookup,
        output rd_addr_seat_lookup,
        input  rd_data_seat_lookup,
        output busy_seat_lookup,
        output done_seat_lookup,
        output found_seat_lookup,
        output Seat_No_out_seat_lookup,
        output Student_No_out_seat_lookup
    );
endinterface

// File: rtl/seat_lookup.sv
// Seat table lookup engine: finds the seat holding a student number by a
// linear scan, or reads back the student stored at one seat. Drives the
// table's one-cycle-latency read port and returns a registered result with
// a single-cycle done pulse.
module seat_lookup #(
    parameter int unsigned NUM_SEATS = 32,
    parameter int unsigned STU_W     = 25,
    parameter int unsigned SEAT_W    = 8
) (
    input logic          clk_seat_lookup,
    input logic          reset_n_seat_lookup,
    seat_lookup_if.slave bus
);
    localparam int unsigned AW = $clog2(NUM_SEATS);
    localparam logic [AW-1:0]     LastAddr = AW'(NUM_SEATS - 1);
    localparam logic [SEAT_W-1:0] MissSeat = '1;

    typedef enum logic [1:0] {StIdle, StScan, StLast} state_e;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [STU_W-1:0]  key_q, key_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    // Address whose data is on rd_data this cycle, and whether it is valid.
    logic              cmp_vld_q, cmp_vld_d;
    logic [AW-1:0]     cmp_addr_q, cmp_addr_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [SEAT_W-1:0] seat_out_q, seat_out_d;
    logic [STU_W-1:0]  stu_out_q, stu_out_d;

    // Next-state, read issue and result capture.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        key_d      = key_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        cmp_vld_d  = rd_en_q;
        cmp_addr_d = rd_addr_q;
        done_d     = 1'b0;
        found_d    = found_q;
        seat_out_d = seat_out_q;
        stu_out_d  = stu_out_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_seat_lookup) begin
                    mode_d = bus.mode_seat_lookup;
                    key_d  = bus.Student_No_seat_lookup;
                    if (!bus.mode_seat_lookup && bus.Student_No_seat_lookup != '0) begin
                        state_d   = StScan;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end else if (bus.mode_seat_lookup &&
                                 32'(bus.Seat_No_seat_lookup) < NUM_SEATS) begin
                        state_d   = StScan;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.Seat_No_seat_lookup[AW-1:0];
                    end else begin
                        // Key 0 or out-of-range seat: answer without touching the table.
                        done_d     = 1'b1;
                        found_d    = 1'b0;
                        seat_out_d = MissSeat;
                        stu_out_d  = '0;
                    end
                end
            end
            StScan: begin
                if (!mode_q && cmp_vld_q && bus.rd_data_seat_lookup == key_q) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    found_d    = 1'b1;
                    seat_out_d = SEAT_W'(cmp_addr_q);
                    stu_out_d  = key_q;
                end else if (mode_q || rd_addr_q == LastAddr) begin
                    // Nothing left to issue; only the in-flight entry remains.
                    state_d = StLast;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            StLast: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (mode_q) begin
                    found_d    = (bus.rd_data_seat_lookup != '0);
                    seat_out_d = SEAT_W'(cmp_addr_q);
                    stu_out_d  = bus.rd_data_seat_lookup;
                end else if (bus.rd_data_seat_lookup == key_q) begin
                    found_d    = 1'b1;
                    seat_out_d = SEAT_W'(cmp_addr_q);
                    stu_out_d  = key_q;
                end else begin
                    found_d    = 1'b0;
                    seat_out_d = MissSeat;
                    stu_out_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_seat_lookup) begin
        if (!reset_n_seat_lookup) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            key_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            seat_out_q <= MissSeat;
            stu_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            key_q      <= key_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            cmp_vld_q  <= cmp_vld_d;
            cmp_addr_q <= cmp_addr_d;
            done_q     <= done_d;
            found_q    <= found_d;
            seat_out_q <= seat_out_d;
            stu_out_q  <= stu_out_d;
        end
    end

    assign bus.rd_en_seat_lookup          = rd_en_q;
    assign bus.rd_addr_seat_lookup        = rd_addr_q;
    assign bus.busy_seat_lookup           = (state_q != StIdle);
    assign bus.done_seat_lookup           = done_q;
    assign bus.found_seat_lookup          = found_q;
    assign bus.Seat_No_out_seat_lookup    = seat_out_q;
    assign bus.Student_No_out_seat_lookup = stu_out_q;
endmodule

// File: tb/tb_seat_lookup.sv
// Directed bench for seat_lookup: table-driven requests plus hand-written
// reset, start-while-busy and mid-scan reset sequences.
module tb_seat_lookup;
    logic clk;
    logic rst_n;

    seat_lookup_if #(.NUM_SEATS(32), .STU_W(25), .SEAT_W(8)) bus ();

    seat_lookup #(.NUM_SEATS(32), .STU_W(25), .SEAT_W(8)) dut (
        .clk_seat_lookup     (clk),
        .reset_n_seat_lookup (rst_n),
        .bus                 (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] mem [32];
    int          rd_log [$];
    int          checks;
    int          errors;

    // Table model: one-cycle synchronous read.
    always @(posedge clk) begin
        if (bus.rd_en_seat_lookup === 1'b1) bus.rd_data_seat_lookup <= mem[bus.rd_addr_seat_lookup];
    end

    // Read-address log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.rd_en_seat_lookup === 1'b1) rd_log.push_back(int'(bus.rd_addr_seat_lookup));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge; returns at the negedge of the done cycle.
    task automatic do_req(input logic m, input logic [24:0] k, input logic [7:0] s,
                          output int lat, output logic f, output logic [7:0] so,
                          output logic [24:0] sto, output logic hold_ok, output logic end_ok);
        logic        f0;
        logic [7:0]  so0;
        logic [24:0] sto0;
        f0   = bus.found_seat_lookup;
        so0  = bus.Seat_No_out_seat_lookup;
        sto0 = bus.Student_No_out_seat_lookup;
        rd_log.delete();
        bus.start_seat_lookup      = 1'b1;
        bus.mode_seat_lookup       = m;
        bus.Student_No_seat_lookup = k;
        bus.Seat_No_seat_lookup    = s;
        @(negedge clk);
        bus.start_seat_lookup = 1'b0;
        lat     = 1;
        hold_ok = 1'b1;
        while (bus.done_seat_lookup !== 1'b1 && lat < 60) begin
            if (bus.busy_seat_lookup !== 1'b1 || bus.found_seat_lookup !== f0 ||
                bus.Seat_No_out_seat_lookup !== so0 || bus.Student_No_out_seat_lookup !== sto0)
                hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (bus.done_seat_lookup !== 1'b1) lat = 999;
        f      = bus.found_seat_lookup;
        so     = bus.Seat_No_out_seat_lookup;
        sto    = bus.Student_No_out_seat_lookup;
        end_ok = (bus.busy_seat_lookup === 1'b0) && (bus.rd_en_seat_lookup === 1'b0);
    endtask

    typedef struct {
        logic        mode;
        logic [24:0] key;
        logic [7:0]  seat;
        int          lat;
        logic        found;
        logic [7:0]  seat_out;
        logic [24:0] stu_out;
        int          nrd;
        int          last;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          lat;
        int          n;
        int          ndone;
        logic        f;
        logic        hold_ok;
        logic        end_ok;
        logic        seq_ok;
        logic [7:0]  so;
        logic [24:0] sto;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0]  = 25'd4242;
        mem[3]  = 25'd555;
        mem[5]  = 25'd2023001;
        mem[7]  = 25'd77;
        mem[9]  = 25'd555;
        mem[31] = 25'd999;

        vecs[0]  = '{1'b0, 25'd2023001, 8'd0,   8,  1'b1, 8'd5,   25'd2023001, 7,  6};
        vecs[1]  = '{1'b0, 25'd1234567, 8'd0,   34, 1'b0, 8'hFF,  25'd0,       32, 31};
        vecs[2]  = '{1'b0, 25'd555,     8'd0,   6,  1'b1, 8'd3,   25'd555,     5,  4};
        vecs[3]  = '{1'b1, 25'd0,       8'd7,   3,  1'b1, 8'd7,   25'd77,      1,  7};
        vecs[4]  = '{1'b1, 25'd0,       8'd2,   3,  1'b0, 8'd2,   25'd0,       1,  2};
        vecs[5]  = '{1'b1, 25'd0,       8'd40,  1,  1'b0, 8'hFF,  25'd0,       0,  0};
        vecs[6]  = '{1'b0, 25'd0,       8'd0,   1,  1'b0, 8'hFF,  25'd0,       0,  0};
        vecs[7]  = '{1'b0, 25'd999,     8'd0,   34, 1'b1, 8'd31,  25'd999,     32, 31};
        vecs[8]  = '{1'b0, 25'd4242,    8'd0,   3,  1'b1, 8'd0,   25'd4242,    2,  1};
        vecs[9]  = '{1'b1, 25'd0,       8'd31,  3,  1'b1, 8'd31,  25'd999,     1,  31};
        vecs[10] = '{1'b1, 25'd0,       8'd32,  1,  1'b0, 8'hFF,  25'd0,       0,  0};
        vecs[11] = '{1'b1, 25'd0,       8'd255, 1,  1'b0, 8'hFF,  25'd0,       0,  0};

        // Reset with random inputs and start held high.
        rst_n                      = 1'b0;
        bus.start_seat_lookup      = 1'b1;
        bus.mode_seat_lookup       = 1'($urandom);
        bus.Student_No_seat_lookup = 25'($urandom);
        bus.Seat_No_seat_lookup    = 8'($urandom);
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy_seat_lookup), 32'd0);
        chk("rst_done",    32'(bus.done_seat_lookup), 32'd0);
        chk("rst_found",   32'(bus.found_seat_lookup), 32'd0);
        chk("rst_seat",    32'(bus.Seat_No_out_seat_lookup), 32'hFF);
        chk("rst_stu",     32'(bus.Student_No_out_seat_lookup), 32'd0);
        chk("rst_rd_en",   32'(bus.rd_en_seat_lookup), 32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr_seat_lookup), 32'd0);
        @(negedge clk);
        chk("rst_start_ignored", 32'(bus.busy_seat_lookup | bus.done_seat_lookup), 32'd0);
        bus.start_seat_lookup = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven requests.
        for (int v = 0; v < 12; v++) begin
            do_req(vecs[v].mode, vecs[v].key, vecs[v].seat, lat, f, so, sto, hold_ok, end_ok);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("v%0d_found", v), 32'(f), 32'(vecs[v].found));
            chk($sformatf("v%0d_seat_out", v), 32'(so), 32'(vecs[v].seat_out));
            chk($sformatf("v%0d_stu_out", v), 32'(sto), 32'(vecs[v].stu_out));
            chk($sformatf("v%0d_rd_count", v), 32'(rd_log.size()), 32'(vecs[v].nrd));
            if (rd_log.size() > 0)
                chk($sformatf("v%0d_last_addr", v), 32'(rd_log[rd_log.size()-1]),
                    32'(vecs[v].last));
            seq_ok = 1'b1;
            foreach (rd_log[i]) begin
                if (rd_log[i] != (vecs[v].mode ? int'(vecs[v].seat) : i)) seq_ok = 1'b0;
            end
            chk($sformatf("v%0d_addr_seq", v), 32'(seq_ok), 32'd1);
            chk($sformatf("v%0d_hold_busy", v), 32'(hold_ok), 32'd1);
            chk($sformatf("v%0d_done_idle", v), 32'(end_ok), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", v), 32'(bus.done_seat_lookup), 32'd0);
        end

        // Duplicate key with start held high through busy; restart in the done cycle.
        bus.start_seat_lookup      = 1'b1;
        bus.mode_seat_lookup       = 1'b0;
        bus.Student_No_seat_lookup = 25'd555;
        @(negedge clk);
        bus.mode_seat_lookup    = 1'b1;
        bus.Seat_No_seat_lookup = 8'd7;
        n     = 1;
        ndone = 0;
        while (bus.done_seat_lookup !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("dup_latency", 32'(n), 32'd6);
        chk("dup_seat", 32'(bus.Seat_No_out_seat_lookup), 32'd3);
        chk("dup_found", 32'(bus.found_seat_lookup), 32'd1);
        @(negedge clk);
        bus.start_seat_lookup = 1'b0;
        chk("restart_busy", 32'(bus.busy_seat_lookup), 32'd1);
        n = 1;
        while (bus.done_seat_lookup !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("restart_latency", 32'(n), 32'd3);
        chk("restart_stu", 32'(bus.Student_No_out_seat_lookup), 32'd77);
        chk("restart_seat", 32'(bus.Seat_No_out_seat_lookup), 32'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done_seat_lookup === 1'b1) ndone++;
        end
        chk("restart_no_extra_done", 32'(ndone), 32'd0);

        // Reset in the middle of a full scan.
        bus.start_seat_lookup      = 1'b1;
        bus.mode_seat_lookup       = 1'b0;
        bus.Student_No_seat_lookup = 25'd1234567;
        @(negedge clk);
        bus.start_seat_lookup = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_before_reset", 32'(bus.busy_seat_lookup), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",  32'(bus.busy_seat_lookup), 32'd0);
        chk("mid_rst_rd_en", 32'(bus.rd_en_seat_lookup), 32'd0);
        chk("mid_rst_done",  32'(bus.done_seat_lookup), 32'd0);
        chk("mid_rst_seat",  32'(bus.Seat_No_out_seat_lookup), 32'hFF);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done_seat_lookup === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);
        do_req(1'b0, 25'd2023001, 8'd0, lat, f, so, sto, hold_ok, end_ok);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_seat", 32'(so), 32'd5);
        chk("post_rst_found", 32'(f), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
